pwm_bus_master: RTL and testbench
=================================

PWM_BUS_MASTER -- requirements
Module: pwm_bus_master

Interface
REQ-001 The block SHALL have one parameter, BASE_ADDR, default 32'h0: byte address of channel 0 enable register.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 res  input  1  reset, asynchronous, active-low (0 = reset asserted).
REQ-004 cmd_valid  input  1  host command present.
REQ-005 cmd_ready  output  1  block can accept a command.
REQ-006 cmd_op  input  2  operation: 0 write, 1 read, 2 broadcast write, 3 reserved.
REQ-007 cmd_ch  input  3  target channel 0..7.
REQ-008 cmd_field  input  2  register: 0 enable, 1 duty, 2 period, 3 reserved.
REQ-009 cmd_wdata  input  32  write data.
REQ-010 rsp_valid  output  1  one-cycle completion pulse.
REQ-011 rsp_err  output  1  command rejected; qualified by rsp_valid.
REQ-012 rsp_rdata  output  32  read result; qualified by rsp_valid.
REQ-013 bus_wr  output  1  write strobe to the PWM register bank.
REQ-014 bus_rd  output  1  read strobe to the PWM register bank.
REQ-015 bus_addr  output  32  byte address.
REQ-016 bus_wdata  output  32  write data.
REQ-017 bus_rdata  input  32  registered read data from the bank; valid one cycle after the bus_rd cycle.

Function
REQ-018 A command SHALL be accepted on a rising edge where cmd_valid and cmd_ready are both 1; the block SHALL register cmd_op, cmd_ch, cmd_field and cmd_wdata at that edge.
REQ-019 cmd_ready SHALL be 1 only in state IDLE; commands offered in any other state SHALL be ignored.
REQ-020 The address SHALL be BASE_ADDR + ch*12 + field*4, computed modulo 2^32.
REQ-021 States SHALL be IDLE, WR, RD, RWAIT, BCAST, RSP; all outputs SHALL be registered.
REQ-022 Write, op 0 (accepted at edge A): WR for cycle A+1 with bus_wr=1 and addr/wdata driven; RSP in A+2 with rsp_valid=1 and rsp_err=0; IDLE in A+3.
REQ-023 Read, op 1: RD in A+1 with bus_rd=1; RWAIT in A+2; bus_rdata sampled at the end of A+2; RSP in A+3 with rsp_rdata equal to the sampled value.
REQ-024 Broadcast, op 2: BCAST for cycles A+1..A+8 with bus_wr=1, channel counter 0..7 ascending, same field and wdata; RSP in A+9. cmd_ch SHALL be ignored for this op.
REQ-025 If cmd_op=3, or cmd_field=3 for any op, the block SHALL go directly to RSP in A+1 with rsp_err=1 and SHALL NOT assert any bus strobe.
REQ-026 bus_wr and bus_rd SHALL never be 1 in the same cycle; each strobe SHALL be high for exactly one cycle per register access.
REQ-027 rsp_rdata SHALL be 0 for write, broadcast and error responses; it SHALL hold its value between responses.
REQ-028 bus_addr and bus_wdata SHALL hold their last value when no strobe is asserted.
REQ-029 rsp_valid SHALL be high for one cycle only; there SHALL be no response backpressure.
REQ-030 In RSP, cmd_ready SHALL be 0; the earliest next acceptance SHALL be at the edge ending the first IDLE cycle.

Reset
REQ-031 While res=0, the block SHALL immediately force state=IDLE, broadcast counter=0, and all outputs to 0, including cmd_ready.
REQ-032 cmd_ready SHALL rise at the first rising edge after res returns to 1.
REQ-033 If reset is asserted mid-operation, including mid-broadcast, the operation SHALL be abandoned with no response pulse and no further strobes.

Verification
REQ-034 Write: op0, ch3, field1, data 0x0000_1388 -> one bus_wr cycle with addr 0x28 and wdata 0x1388; rsp_valid 2 cycles after accept; rsp_err=0.
REQ-035 Read: preload the bank model e7=0x1, then op1, ch7, field0 -> bus_rd with addr 0x54; rsp_rdata=0x1 three cycles after accept.
REQ-036 Broadcast: op2, field2, data 0x000F_4240 -> 8 consecutive bus_wr cycles at addrs 0x08, 0x14, ..., 0x5C; rsp_valid at A+9.
REQ-037 Illegal: op0, field3 -> rsp_valid with rsp_err=1 at A+1; no strobes.
REQ-038 Reset at the BCAST cycle for ch4 -> outputs 0 at once; no further bus_wr; no rsp_valid; cmd_ready=1 at the first edge after release.
REQ-039 Back-to-back: cmd_valid held high with two writes -> second accept exactly 3 cycles after the first; cmd_valid during a busy state is ignored.

Source files
------------

// File: rtl/pwm_bus_master.sv
// PWM register-bank bus master: host commands become bus strobes.
// Single write, single read and eight-channel broadcast write.
module pwm_bus_master #(
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic        clk,
  input  logic        res,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [2:0]  cmd_ch,
  input  logic [1:0]  cmd_field,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic        rsp_err,
  output logic [31:0] rsp_rdata,
  output logic        bus_wr,
  output logic        bus_rd,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [2:0] {
    IDLE, WR, RD, RWAIT, BCAST, RSP
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [1:0]  field_q, field_d;
  logic        ready_d, rv_d, err_d;
  logic        wr_d, rd_d;
  logic [31:0] rdata_d, addr_d, wdata_d;
  logic        illegal;

  function automatic logic [31:0] reg_addr(
    input logic [2:0] ch,
    input logic [1:0] fld
  );
    return BASE_ADDR
         + {29'd0, ch} * 32'd12
         + {28'd0, fld, 2'b00};
  endfunction

  assign illegal = (cmd_op == 2'd3)
                || (cmd_field == 2'd3);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    field_d = field_q;
    ready_d = 1'b0;
    rv_d    = 1'b0;
    err_d   = 1'b0;
    wr_d    = 1'b0;
    rd_d    = 1'b0;
    rdata_d = rsp_rdata;
    addr_d  = bus_addr;
    wdata_d = bus_wdata;
    unique case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (cmd_valid && cmd_ready) begin
          ready_d = 1'b0;
          field_d = cmd_field;
          if (illegal) begin
            state_d = RSP;
            rv_d    = 1'b1;
            err_d   = 1'b1;
            rdata_d = '0;
          end else begin
            unique case (1'b1)
              cmd_op == 2'd0: begin
                state_d = WR;
                wr_d    = 1'b1;
                addr_d  = reg_addr(cmd_ch, cmd_field);
                wdata_d = cmd_wdata;
              end
              cmd_op == 2'd1: begin
                state_d = RD;
                rd_d    = 1'b1;
                addr_d  = reg_addr(cmd_ch, cmd_field);
              end
              default: begin
                state_d = BCAST;
                cnt_d   = '0;
                wr_d    = 1'b1;
                addr_d  = reg_addr(3'd0, cmd_field);
                wdata_d = cmd_wdata;
              end
            endcase
          end
        end
      end
      WR: begin
        state_d = RSP;
        rv_d    = 1'b1;
        rdata_d = '0;
      end
      RD: state_d = RWAIT;
      RWAIT: begin
        // bank data is registered, valid the cycle after bus_rd
        state_d = RSP;
        rv_d    = 1'b1;
        rdata_d = bus_rdata;
      end
      BCAST: begin
        if (cnt_q == 3'd7) begin
          state_d = RSP;
          rv_d    = 1'b1;
          rdata_d = '0;
        end else begin
          cnt_d  = cnt_q + 3'd1;
          wr_d   = 1'b1;
          addr_d = reg_addr(cnt_q + 3'd1, field_q);
        end
      end
      RSP: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      field_q   <= '0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      bus_wr    <= 1'b0;
      bus_rd    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      field_q   <= field_d;
      cmd_ready <= ready_d;
      rsp_valid <= rv_d;
      rsp_err   <= err_d;
      rsp_rdata <= rdata_d;
      bus_wr    <= wr_d;
      bus_rd    <= rd_d;
      bus_addr  <= addr_d;
      bus_wdata <= wdata_d;
    end
  end

endmodule

// File: tb/tb_pwm_bus_master.sv
// Bench for pwm_bus_master: transaction-level model plus bank responder.
// Directed cases pin the model, then randomized traffic with resets.
module tb_pwm_bus_master;

  localparam logic [31:0] BASE = 32'h0;

  logic        clk = 1'b0;
  logic        res;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [2:0]  cmd_ch;
  logic [1:0]  cmd_field;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_err;
  logic [31:0] rsp_rdata;
  logic        bus_wr;
  logic        bus_rd;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;

  always #5 clk = ~clk;

  pwm_bus_master #(.BASE_ADDR(BASE)) dut (
    .clk(clk), .res(res),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_ch(cmd_ch),
    .cmd_field(cmd_field), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err),
    .rsp_rdata(rsp_rdata),
    .bus_wr(bus_wr), .bus_rd(bus_rd),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] bank    [24];
  logic [31:0] ref_mem [24];

  function automatic int idx_of(input logic [31:0] a);
    logic [31:0] o;
    o = a - BASE;
    if (o >= 32'd96 || o[1:0] != 2'b00) return -1;
    return int'(o / 32'd12) * 3 + int'((o % 32'd12) / 32'd4);
  endfunction

  // register bank seen by the DUT; read data registered
  always @(posedge clk) begin
    int i;
    i = idx_of(bus_addr);
    if (bus_rd && i >= 0) bus_rdata <= bank[i];
    else bus_rdata <= $urandom;
    if (bus_wr && i >= 0) bank[i] = bus_wdata;
  end

  typedef struct {
    logic        wr, rd, rv, err, rdy;
    logic [31:0] addr, wdata, rdata;
    int          idx;
  } ent_t;

  ent_t        q[$];
  ent_t        cur;
  logic [31:0] last_addr, last_wdata, last_rdata;

  function automatic ent_t blank();
    ent_t e;
    e.wr = 0; e.rd = 0; e.rv = 0; e.err = 0; e.rdy = 0;
    e.addr = 0; e.wdata = 0; e.rdata = 0; e.idx = 0;
    return e;
  endfunction

  function automatic logic [31:0] addr_of(input int ch, input int f);
    return BASE + 32'(ch * 12 + f * 4);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_cycle();
    chk("cmd_ready", 32'(cmd_ready), 32'(cur.rdy));
    chk("rsp_valid", 32'(rsp_valid), 32'(cur.rv));
    if (cur.rv) chk("rsp_err", 32'(rsp_err), 32'(cur.err));
    chk("rsp_rdata", rsp_rdata, last_rdata);
    chk("bus_wr", 32'(bus_wr), 32'(cur.wr));
    chk("bus_rd", 32'(bus_rd), 32'(cur.rd));
    chk("bus_addr", bus_addr, last_addr);
    chk("bus_wdata", bus_wdata, last_wdata);
  endtask

  // advance the transaction model across one rising edge
  task automatic model_edge();
    ent_t e;
    int   f, c;
    if (cur.wr) ref_mem[cur.idx] = cur.wdata;
    if (cmd_valid && cur.rdy) begin
      f = int'(cmd_field);
      c = int'(cmd_ch);
      e = blank();
      if (cmd_op == 2'd3 || cmd_field == 2'd3) begin
        e.rv = 1; e.err = 1; q.push_back(e);
      end else begin
        case (cmd_op)
          2'd0: begin
            e.wr = 1; e.addr = addr_of(c, f);
            e.wdata = cmd_wdata; e.idx = c * 3 + f;
            q.push_back(e);
            e = blank(); e.rv = 1; q.push_back(e);
          end
          2'd1: begin
            e.rd = 1; e.addr = addr_of(c, f);
            q.push_back(e);
            e = blank(); q.push_back(e);
            e.rv = 1; e.rdata = ref_mem[c * 3 + f];
            q.push_back(e);
          end
          default: begin
            for (int k = 0; k < 8; k++) begin
              e = blank(); e.wr = 1; e.addr = addr_of(k, f);
              e.wdata = cmd_wdata; e.idx = k * 3 + f;
              q.push_back(e);
            end
            e = blank(); e.rv = 1; q.push_back(e);
          end
        endcase
      end
    end
    if (q.size() > 0) cur = q.pop_front();
    else begin
      cur = blank(); cur.rdy = 1;
    end
    if (cur.wr) begin
      last_addr = cur.addr; last_wdata = cur.wdata;
    end
    if (cur.rd) last_addr = cur.addr;
    if (cur.rv) last_rdata = cur.rdata;
  endtask

  task automatic step(input logic v, input logic [1:0] op,
                      input logic [2:0] ch, input logic [1:0] f,
                      input logic [31:0] d);
    cmd_valid = v; cmd_op = op; cmd_ch = ch;
    cmd_field = f; cmd_wdata = d;
    @(posedge clk);
    model_edge();
    #2;
    check_cycle();
  endtask

  task automatic idle();
    step(1'b0, 2'($urandom), 3'($urandom), 2'($urandom), $urandom);
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 12 && !cur.rdy; i++) idle();
    chk("wait_ready", 32'(cur.rdy), 32'd1);
  endtask

  task automatic do_reset(input int hold);
    res = 1'b0;
    #1;
    q.delete();
    cur = blank();
    last_addr = 0; last_wdata = 0; last_rdata = 0;
    check_cycle();
    repeat (hold) begin
      @(posedge clk); #2; check_cycle();
    end
    res = 1'b1;
    #1;
    check_cycle();
  endtask

  logic [31:0] bc_addr [8];

  initial begin
    bc_addr = '{32'h08, 32'h14, 32'h20, 32'h2C,
                32'h38, 32'h44, 32'h50, 32'h5C};
    for (int i = 0; i < 24; i++) begin
      bank[i] = $urandom; ref_mem[i] = bank[i];
    end
    cur = blank();
    last_addr = 0; last_wdata = 0; last_rdata = 0;
    cmd_valid = 0; cmd_op = 0; cmd_ch = 0;
    cmd_field = 0; cmd_wdata = 0;
    res = 1'b1;
    #3;
    do_reset(2);
    chk("lit_ready_in_reset", 32'(cmd_ready), 32'd0);
    idle();
    chk("lit_ready_after_rst", 32'(cmd_ready), 32'd1);

    // single write
    step(1'b1, 2'd0, 3'd3, 2'd1, 32'h0000_1388);
    chk("lit_wr_strobe", 32'(bus_wr), 32'd1);
    chk("lit_wr_addr", bus_addr, 32'h28);
    chk("lit_wr_data", bus_wdata, 32'h1388);
    idle();
    chk("lit_wr_rsp", 32'(rsp_valid), 32'd1);
    chk("lit_wr_err", 32'(rsp_err), 32'd0);
    wait_ready();

    // read of preloaded channel 7 enable
    bank[21] = 32'h1; ref_mem[21] = 32'h1;
    step(1'b1, 2'd1, 3'd7, 2'd0, $urandom);
    chk("lit_rd_strobe", 32'(bus_rd), 32'd1);
    chk("lit_rd_addr", bus_addr, 32'h54);
    idle();
    idle();
    chk("lit_rd_rsp", 32'(rsp_valid), 32'd1);
    chk("lit_rd_data", rsp_rdata, 32'h1);
    wait_ready();

    // broadcast period
    step(1'b1, 2'd2, 3'd5, 2'd2, 32'h000F_4240);
    for (int k = 0; k < 8; k++) begin
      chk("lit_bc_strobe", 32'(bus_wr), 32'd1);
      chk("lit_bc_addr", bus_addr, bc_addr[k]);
      idle();
    end
    chk("lit_bc_rsp", 32'(rsp_valid), 32'd1);
    chk("lit_bc_rdata", rsp_rdata, 32'd0);
    wait_ready();

    // illegal field
    step(1'b1, 2'd0, 3'd1, 2'd3, $urandom);
    chk("lit_ill_rsp", 32'(rsp_valid), 32'd1);
    chk("lit_ill_err", 32'(rsp_err), 32'd1);
    chk("lit_ill_wr", 32'(bus_wr), 32'd0);
    wait_ready();

    // back-to-back writes with cmd_valid held
    step(1'b1, 2'd0, 3'd0, 2'd0, 32'hAAAA_0001);
    chk("lit_b2b_first", bus_wdata, 32'hAAAA_0001);
    step(1'b1, 2'd0, 3'd1, 2'd1, 32'hBBBB_0002);
    chk("lit_b2b_busy1", 32'(bus_wr), 32'd0);
    step(1'b1, 2'd0, 3'd1, 2'd1, 32'hBBBB_0002);
    chk("lit_b2b_busy2", 32'(bus_wr), 32'd0);
    step(1'b1, 2'd0, 3'd1, 2'd1, 32'hBBBB_0002);
    chk("lit_b2b_second", 32'(bus_wr), 32'd1);
    chk("lit_b2b_data", bus_wdata, 32'hBBBB_0002);
    wait_ready();

    // reset during broadcast of channel 4
    step(1'b1, 2'd2, 3'd0, 2'd1, 32'h1234_5678);
    repeat (4) idle();
    chk("lit_bc4_addr", bus_addr, 32'h34);
    do_reset(2);
    chk("lit_rst_wr", 32'(bus_wr), 32'd0);
    chk("lit_rst_addr", bus_addr, 32'd0);
    idle();
    chk("lit_rel_ready", 32'(cmd_ready), 32'd1);
    chk("lit_rel_rsp", 32'(rsp_valid), 32'd0);

    // randomized traffic with occasional resets
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 149) == 0) do_reset($urandom_range(0, 2));
      step($urandom_range(0, 3) != 0,
           2'($urandom_range(0, 3)),
           3'($urandom),
           ($urandom_range(0, 9) == 0) ? 2'd3
                                       : 2'($urandom_range(0, 2)),
           $urandom);
    end
    wait_ready();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
